bitblade_acc: RTL and testbench
===============================

BITBLADE_ACC -- requirements
Module: bitblade_acc

Interface
REQ-001 Parameter W, default 32, operand width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter ACC_W, default 32, accumulator and result width in bits.
REQ-003 Parameter A_OFFSET, default 128, signed 9-bit offset added to each 8-bit a element in mode 0.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_op  in  2  operation code: 00 MAC, 01 MAC_LAST, 10 CLEAR, 11 READ.
REQ-009 mode  in  2  element precision: 00 8-bit signed, 01 4-bit unsigned, 10 2-bit unsigned, 11 reserved.
REQ-010 in_a  in  W  packed a elements; element k occupies the bits at k*size and above.
REQ-011 in_b  in  W  packed b elements, packed the same way as in_a.
REQ-012 rsp_valid  out  1  result available.
REQ-013 rsp_ready  in  1  result consumed when rsp_valid && rsp_ready.
REQ-014 rsp_data  out  ACC_W  result value.
REQ-015 busy  out  1  high while any accepted command is still in the pipeline or a result is held.

Function
REQ-016 Beat sum, per mode:
- mode 00: sum over W/8 lanes of (sext(a_k)+A_OFFSET)*sext(b_k), computed signed.
- mode 01: sum over W/4 lanes of a_k*b_k, unsigned.
- mode 10: sum over W/2 lanes of a_k*b_k, unsigned.
- mode 11: beat sum SHALL be 0.
REQ-017 The beat sum SHALL be sign-extended to ACC_W; accumulation SHALL wrap modulo 2^ACC_W, with no saturation.
REQ-018 Pipeline:
- stage 1 registers the beat sum and the op at the accept edge T.
- stage 2 updates the accumulator at T+1.
- a response, if any, is registered so rsp_valid rises at edge T+2.
REQ-019 MAC: acc <= acc + beat sum; produces no response.
REQ-020 MAC_LAST: rsp_data <= acc + beat sum, and acc <= 0 in the same cycle.
REQ-021 READ: rsp_data <= acc, which includes every earlier-accepted MAC; acc is unchanged; in_a and in_b are ignored.
REQ-022 CLEAR: acc <= 0 at stage 2; produces no response.
REQ-023 Back-to-back MAC/CLEAR commands SHALL be accepted one per cycle with no bubbles.
REQ-024 Only one response may be outstanding: cmd_ready SHALL be low while a MAC_LAST/READ is in stage 1 or 2, or rsp_valid && !rsp_ready.
REQ-025 rsp_valid and rsp_data SHALL hold stable until rsp_ready; rsp_valid falls on the edge after the handshake unless a new response is registered on that edge.
REQ-026 If rsp_valid && rsp_ready at edge E, cmd_ready SHALL be high in the cycle after E (assuming no other response op is in flight).
REQ-027 A command presented while cmd_ready is low SHALL have no effect; the sender holds cmd_op, mode, in_a and in_b until accepted.
REQ-028 mode is sampled per beat; beats of mixed modes SHALL accumulate into the same acc.
REQ-029 busy SHALL equal (stage1 valid || stage2 valid || rsp_valid).

Reset
REQ-030 On rst_n low, asynchronously: acc = 0, pipeline valids = 0, rsp_valid = 0, rsp_data = 0, busy = 0, cmd_ready = 0.
REQ-031 cmd_ready SHALL rise in the first cycle after rst_n is deasserted.
REQ-032 Reset mid-operation SHALL discard in-flight commands and any pending response; no stale response appears afterwards.

Verification
REQ-033 Mode 01, MAC_LAST a=0x11111111 b=0x22222222 (W=32) -> rsp_valid at T+2, rsp_data=16; a following READ returns 0.
REQ-034 Mode 00, MAC a=0x01020304 b=0x01010101, then MAC_LAST a=0x80808080 b=0x7F7F7F7F -> rsp_data=522 (129+130+131+132, then 0).
REQ-035 Mode 10, three back-to-back MACs a=b=0xFFFFFFFF, then READ -> cmd_ready high throughout the MACs; rsp_data=432; a second READ returns 432.
REQ-036 Backpressure: READ with rsp_ready held low 5 cycles -> rsp_data stable and cmd_ready low for those cycles; after the handshake the next command is accepted the following cycle.
REQ-037 Wrap and clear, ACC_W=8: MACs summing to 300 then READ -> 44; CLEAR then READ -> 0; mode 11 MAC leaves acc unchanged.
REQ-038 Reset: assert rst_n low one cycle after a MAC_LAST is accepted -> no rsp_valid after release; READ returns 0.

Source files
------------

// File: rtl/bitblade_acc.sv
// Bit-sliced multiply-accumulate with per-beat precision (8b signed / 4b / 2b unsigned lanes).
// Latency: beat sum registered at accept edge T, acc updated at T+1, response valid at T+2.
// Backpressure: one response outstanding; cmd_ready drops while a MAC_LAST/READ is in flight or held.
module bitblade_acc #(
  parameter int                 W        = 32,
  parameter int                 ACC_W    = 32,
  parameter logic signed [8:0]  A_OFFSET = 9'sd128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ACC_W-1:0] rsp_data,
  output logic             busy
);

  localparam logic [1:0] OP_MAC   = 2'b00;
  localparam logic [1:0] OP_LAST  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  // Internal sum is wide enough for every lane product of a full beat, and never
  // narrower than the accumulator, so the final slice is both sign-extension and wrap.
  localparam int LOG_W = $clog2(W);
  localparam int SUM_W = (ACC_W > LOG_W + 24) ? ACC_W : LOG_W + 24;

  logic signed [SUM_W-1:0] beat_full;
  logic signed [SUM_W-1:0] term;
  logic        [ACC_W-1:0] beat_sum;

  logic             s1_vld;
  logic [1:0]       s1_op;
  logic [ACC_W-1:0] s1_sum;
  logic             s2_vld;
  logic [1:0]       s2_op;
  logic [ACC_W-1:0] s2_val;
  logic [ACC_W-1:0] acc;
  logic             rdy_en;

  logic cmd_fire;
  logic s1_rsp;
  logic s2_rsp;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign s1_rsp   = s1_vld & ((s1_op == OP_LAST) | (s1_op == OP_READ));
  assign s2_rsp   = s2_vld & ((s2_op == OP_LAST) | (s2_op == OP_READ));

  // Only one response may be in flight or held; a consumed response frees the slot immediately.
  assign cmd_ready = rdy_en & ~s1_rsp & ~s2_rsp & ~(rsp_valid & ~rsp_ready);
  assign busy      = s1_vld | s2_vld | rsp_valid;

  // Lane-wise dot product of the current beat at the precision selected by mode.
  always_comb begin
    beat_full = '0;
    term      = '0;
    case (mode)
      2'b00: begin
        for (int k = 0; k < W / 8; k++) begin
          term = (SUM_W'($signed(in_a[k*8 +: 8])) + SUM_W'(A_OFFSET)) *
                 SUM_W'($signed(in_b[k*8 +: 8]));
          beat_full = beat_full + term;
        end
      end
      2'b01: begin
        for (int k = 0; k < W / 4; k++) begin
          term = $signed(SUM_W'(in_a[k*4 +: 4]) * SUM_W'(in_b[k*4 +: 4]));
          beat_full = beat_full + term;
        end
      end
      2'b10: begin
        for (int k = 0; k < W / 2; k++) begin
          term = $signed(SUM_W'(in_a[k*2 +: 2]) * SUM_W'(in_b[k*2 +: 2]));
          beat_full = beat_full + term;
        end
      end
      default: begin
        beat_full = '0;
      end
    endcase
    beat_sum = beat_full[ACC_W-1:0];
  end

  // cmd_ready is held low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Stage 1: capture op and beat sum; READ/CLEAR operands are irrelevant so carry zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_op  <= OP_MAC;
      s1_sum <= '0;
    end else begin
      s1_vld <= cmd_fire;
      if (cmd_fire) begin
        s1_op  <= cmd_op;
        s1_sum <= ((cmd_op == OP_MAC) || (cmd_op == OP_LAST)) ? beat_sum : '0;
      end
    end
  end

  // Stage 2: update the accumulator and stage the response value for MAC_LAST/READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_op  <= OP_MAC;
      s2_val <= '0;
      acc    <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_op <= s1_op;
        case (s1_op)
          OP_MAC: begin
            acc <= acc + s1_sum;
          end
          OP_LAST: begin
            s2_val <= acc + s1_sum;
            acc    <= '0;
          end
          OP_CLEAR: begin
            acc <= '0;
          end
          default: begin
            s2_val <= acc;
          end
        endcase
      end
    end
  end

  // Response register: holds until consumed; a new response may load on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (s2_rsp) begin
      rsp_valid <= 1'b1;
      rsp_data  <= s2_val;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitblade_acc.sv
module tb_bitblade_acc;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [1:0]  mode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        rsp_ready;

  logic        cmd_ready,  rsp_valid,  busy;
  logic [31:0] rsp_data;
  logic        cmd_ready8, rsp_valid8, busy8;
  logic [7:0]  rsp_data8;

  int checks = 0;
  int errors = 0;

  longint acc_m;
  longint exp_q[$];

  bitblade_acc #(.W(32), .ACC_W(32), .A_OFFSET(9'sd128)) dut32 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .mode(mode), .in_a(in_a), .in_b(in_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  bitblade_acc #(.W(32), .ACC_W(8), .A_OFFSET(9'sd128)) dut8 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready8),
    .cmd_op(cmd_op), .mode(mode), .in_a(in_a), .in_b(in_b),
    .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready), .rsp_data(rsp_data8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference beat value straight from the lane rules, as a plain integer.
  function automatic longint beat_m(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b);
    longint s;
    int av, bv;
    s = 0;
    case (md)
      2'b00: for (int k = 0; k < 4; k++) begin
        av = int'(a[k*8 +: 8]); bv = int'(b[k*8 +: 8]);
        if (av > 127) av -= 256;
        if (bv > 127) bv -= 256;
        s += longint'((av + 128) * bv);
      end
      2'b01: for (int k = 0; k < 8; k++)  s += longint'(int'(a[k*4 +: 4]) * int'(b[k*4 +: 4]));
      2'b10: for (int k = 0; k < 16; k++) s += longint'(int'(a[k*2 +: 2]) * int'(b[k*2 +: 2]));
      default: s = 0;
    endcase
    return s;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with cmd_valid low.
  task automatic send(input logic [1:0] op, input logic [1:0] md, input logic [31:0] a,
                      input logic [31:0] b, output int waited);
    cmd_op = op; mode = md; in_a = a; in_b = b; cmd_valid = 1'b1;
    waited = 0;
    while (!(cmd_ready && cmd_ready8) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      checks++;
      errors++;
      $error("FAIL cmd_accept_timeout: observed cmd_ready=%0b expected 1", cmd_ready);
    end else begin
      @(posedge clk);
      case (op)
        2'b00: acc_m += beat_m(md, a, b);
        2'b01: begin exp_q.push_back(acc_m + beat_m(md, a, b)); acc_m = 0; end
        2'b10: acc_m = 0;
        default: exp_q.push_back(acc_m);
      endcase
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Collects one response and checks it against the model (and a literal when given).
  task automatic get_rsp(input string tag, input bit has_lit, input longint lit);
    longint e;
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
    chk({tag, "_vld"},  {63'd0, rsp_valid},  64'd1);
    chk({tag, "_vld8"}, {63'd0, rsp_valid8}, 64'd1);
    chk({tag, "_d32"},  {32'd0, rsp_data},  {32'd0, e[31:0]});
    chk({tag, "_d8"},   {56'd0, rsp_data8}, {56'd0, e[7:0]});
    if (has_lit) chk({tag, "_lit"}, {32'd0, rsp_data}, lit);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int w;
    logic [1:0] rop;
    logic [1:0] rmd;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; mode = 2'b00;
    in_a = '0; in_b = '0; rsp_ready = 1'b0; acc_m = 0;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_rsp_data",  {32'd0, rsp_data},  64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Mode 01 MAC_LAST latency and value, then READ of the cleared acc
    send(2'b01, 2'b01, 32'h11111111, 32'h22222222, w);
    chk("lat_t0_vld",  {63'd0, rsp_valid}, 64'd0);
    chk("lat_t0_busy", {63'd0, busy},      64'd1);
    @(negedge clk);
    chk("lat_t1_vld",  {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("lat_t2_vld",  {63'd0, rsp_valid}, 64'd1);
    get_rsp("m01_last", 1'b1, 64'd16);
    send(2'b11, 2'b00, 32'hDEADBEEF, 32'h12345678, w);
    get_rsp("m01_read0", 1'b1, 64'd0);

    // Mode 00 signed with offset
    send(2'b00, 2'b00, 32'h01020304, 32'h01010101, w);
    send(2'b01, 2'b00, 32'h80808080, 32'h7F7F7F7F, w);
    get_rsp("m00_last", 1'b1, 64'd522);

    // Mode 10 back-to-back MACs, two READs
    for (int i = 0; i < 3; i++) begin
      send(2'b00, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, w);
      chk("b2b_no_wait", w, 64'd0);
    end
    send(2'b11, 2'b00, 32'h0, 32'h0, w);
    get_rsp("m10_read1", 1'b1, 64'd432);
    send(2'b11, 2'b00, 32'h0, 32'h0, w);
    get_rsp("m10_read2", 1'b1, 64'd432);

    // Backpressure: held response, stalled command has no effect
    send(2'b10, 2'b00, 32'h0, 32'h0, w);
    send(2'b00, 2'b01, 32'h00000003, 32'h00000003, w);
    send(2'b11, 2'b00, 32'h0, 32'h0, w);
    for (int n = 0; n < 40 && !rsp_valid; n++) @(negedge clk);
    cmd_op = 2'b00; mode = 2'b01; in_a = 32'h11111111; in_b = 32'h11111111; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld",       {63'd0, rsp_valid}, 64'd1);
      chk("bp_data",      {32'd0, rsp_data},  64'd9);
      chk("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("bp_after_vld",   {63'd0, rsp_valid}, 64'd0);
    chk("bp_after_ready", {63'd0, cmd_ready}, 64'd1);
    send(2'b11, 2'b00, 32'h0, 32'h0, w);
    chk("bp_next_no_wait", w, 64'd0);
    get_rsp("bp_stray_ignored", 1'b1, 64'd9);

    // Wrap on the 8-bit accumulator, CLEAR, reserved mode
    send(2'b10, 2'b00, 32'h0, 32'h0, w);
    send(2'b00, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, w);
    send(2'b00, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, w);
    send(2'b00, 2'b01, 32'h0000000C, 32'h00000001, w);
    send(2'b11, 2'b00, 32'h0, 32'h0, w);
    for (int n = 0; n < 40 && !rsp_valid; n++) @(negedge clk);
    chk("wrap_d8_lit", {56'd0, rsp_data8}, 64'd44);
    get_rsp("wrap_300", 1'b1, 64'd300);
    send(2'b10, 2'b00, 32'h0, 32'h0, w);
    send(2'b11, 2'b00, 32'h0, 32'h0, w);
    get_rsp("clear_read", 1'b1, 64'd0);
    send(2'b00, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, w);
    send(2'b00, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, w);
    send(2'b11, 2'b00, 32'h0, 32'h0, w);
    get_rsp("mode11_noop", 1'b1, 64'd144);

    // Randomised mixed-mode traffic against the model
    send(2'b10, 2'b00, 32'h0, 32'h0, w);
    for (int i = 0; i < 60; i++) begin
      rop = (($urandom_range(0, 9)) < 6) ? 2'b00 : 2'($urandom_range(0, 3));
      rmd = 2'($urandom_range(0, 3));
      send(rop, rmd, $urandom, $urandom, w);
      if (rop == 2'b01 || rop == 2'b11) get_rsp("rand", 1'b0, 64'd0);
    end
    send(2'b01, 2'b00, $urandom, $urandom, w);
    get_rsp("rand_final", 1'b0, 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Reset with a MAC_LAST in flight
    send(2'b00, 2'b01, 32'h77777777, 32'h55555555, w);
    send(2'b01, 2'b01, 32'h11111111, 32'h11111111, w);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld",   {63'd0, rsp_valid}, 64'd0);
    chk("midrst_busy",  {63'd0, busy},      64'd0);
    chk("midrst_ready", {63'd0, cmd_ready}, 64'd0);
    chk("midrst_data",  {32'd0, rsp_data},  64'd0);
    acc_m = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", {63'd0, rsp_valid}, 64'd0);
    end
    send(2'b11, 2'b00, 32'h0, 32'h0, w);
    get_rsp("midrst_read", 1'b1, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
